quadrature_step_generator: RTL and testbench
============================================

Name: quadrature_step_generator

Overview:
- Transmit side of the two-phase rotary/quadrature interface: converts single-step requests into A/B quadrature waveforms.
- The waveforms are the ones the existing quadrature counter decodes: up is (a,b) 00→10→11→01→00; down is the reverse.
- Used to drive the encoder-decoding path on the board loopback, and to emulate a dial in benches.
- Enforces a minimum dwell between edges, so debounced inputs on the far end resolve every step.

Parameters:
- STEP_DIV, 1024: minimum clk cycles between successive a/b edges (≥2).
- PEND_W, 4: width of the signed pending-step accumulator; MAX = 2^(PEND_W-1)-1.
- COUNT_W, 8: width of the position counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- step_valid  in  1  step request present.
- step_dir  in  1  1 = up (count +1 at decoder), 0 = down.
- step_ready  out  1  request accepted this cycle when step_valid & step_ready.
- a  out  1  quadrature phase A, registered.
- b  out  1  quadrature phase B, registered.
- position  out  COUNT_W  net edges emitted (up +1, down -1), registered.
- busy  out  1  pending != 0.

Behaviour:
- One clock domain only. Reset is synchronous and active-high: rst=1 sampled at a clk rising edge resets all state.
- Reset values:
  - a=0, b=0, position=0, pending=0, busy=0.
  - dwell=STEP_DIV-1 (saturated), so the first step is not delayed.
  - step_ready=1.
- Phase state: 2-bit register {a,b}, Gray sequence only; exactly one of a,b changes per edge.
- Pending accumulator (signed PEND_W):
  - Accept up: +1. Accept down: -1.
  - Opposite requests cancel, e.g. +2 then a down request gives +1.
- step_ready = (pending != +MAX) && (pending != -MAX). It is a function of registered state only; no combinational path from step_valid/step_dir.
- Dwell counter:
  - Increments each cycle, saturating at STEP_DIV-1.
  - Cleared to 0 on the cycle an edge is emitted.
- Edge emission:
  - Condition: dwell==STEP_DIV-1 and the registered pending != 0.
  - pending>0: advance the phase one step up, pending-1, position+1.
  - pending<0: reverse the phase one step, pending+1, position-1.
- Simultaneous accept and emit in the same cycle: pending_next = pending + accept_delta - emit_delta. No request is lost; no double count.
- Latency:
  - Request accepted at edge N updates pending at N.
  - The a/b change is registered at edge N+1 if dwell is saturated.
  - Successive edges are spaced exactly STEP_DIV cycles while pending != 0.
- position wraps modulo 2^COUNT_W: 8'hFF +1 gives 8'h00; 8'h00 -1 gives 8'hFF.
- Pending saturation: a request is never accepted at ±MAX (step_ready low). Producers hold step_valid until accepted.
- Reset mid-operation:
  - a/b go to 00 at the next edge regardless of phase.
  - Pending requests are discarded, and position clears.
  - A jump from 11 to 00 is a non-Gray transition; the far-end decoder ignores it.
- busy is registered with pending and reflects the post-update value.

Optional Feature:
- Macro: QUADGEN_DETENT_EN
- Defined:
  - Each accepted request is one detent = 4 consecutive edges in its direction, spaced STEP_DIV cycles apart.
  - pending counts edges: accept adds ±4, and step_ready requires |pending| ≤ MAX-4.
  - The phase returns to 00 after every full detent when there are no cancellations.
  - position changes by ±4 per detent.
- Undefined: one accepted request = one edge, as above.

Test Plan (STEP_DIV=4, PEND_W=4, COUNT_W=8 unless noted):
- Reset, then one up request at cycle 0 → a/b 00→10 registered at cycle 2; position=1; busy returns to 0; step_ready stays 1.
- Three up requests back-to-back → a/b 00→10→11→01 with edges exactly 4 cycles apart; position=3; decoder model counts +3.
- Up, up, down accepted on consecutive cycles → only one edge (00→10) emitted; position=1; no transient 10→00.
- Hold step_valid=1, step_dir=0 for 20 cycles with no drain → pending reaches -7 and step_ready deasserts; pending never exceeds -7; position decrements by one every 4 cycles; step_ready reasserts after the first emission.
- Start with position=8'h00 and emit one down edge → position=8'hFF and {a,b}=01. Assert rst mid-dwell with pending=+5 → next cycle a=b=0, position=0, busy=0.
- With QUADGEN_DETENT_EN, one up request → four edges 00→10→11→01→00 spaced 4 cycles apart; position=4; step_ready low while pending>3.

Source files
------------

// File: rtl/quadrature_step_generator.sv
// quadrature_step_generator
// Turns single-step requests into A/B quadrature edges with a guaranteed
// minimum dwell between edges. Up is (a,b) 00->10->11->01->00 and down is
// the reverse. Requests accumulate in a signed pending counter that drains
// one edge per STEP_DIV cycles.
//
// Optional feature macro: QUADGEN_DETENT_EN. When it is defined, each
// accepted request is one full detent (4 edges) instead of one edge.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   step_valid  step request present
//   step_dir    1 = up, 0 = down
//   step_ready  request accepted when step_valid & step_ready (registered)
//   a, b        quadrature phases (registered)
//   position    net edges emitted, wraps modulo 2^COUNT_W (registered)
//   busy        pending accumulator non-zero (registered)
module quadrature_step_generator #(
  parameter int unsigned STEP_DIV = 1024,
  parameter int unsigned PEND_W   = 4,
  parameter int unsigned COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  output logic               a,
  output logic               b,
  output logic [COUNT_W-1:0] position,
  output logic               busy
);

  localparam int unsigned DW    = $clog2(STEP_DIV);
  localparam int          MAX_I = (1 << (PEND_W - 1)) - 1;

`ifdef QUADGEN_DETENT_EN
  localparam int          UNIT_I = 4;
`else
  localparam int          UNIT_I = 1;
`endif

  localparam logic [DW-1:0]            DWELL_MAX = DW'(STEP_DIV - 1);
  localparam logic signed [PEND_W-1:0] UNIT_P    = PEND_W'(UNIT_I);
  localparam logic signed [PEND_W-1:0] ONE_P     = PEND_W'(1);
  localparam logic signed [PEND_W-1:0] POS_LIM   = PEND_W'(MAX_I - UNIT_I + 1);
  localparam logic signed [PEND_W-1:0] NEG_LIM   = PEND_W'(-(MAX_I - UNIT_I + 1));

  logic [1:0]               phase_q, phase_d;
  logic signed [PEND_W-1:0] pending_q, pending_d;
  logic [DW-1:0]            dwell_q, dwell_d;
  logic [COUNT_W-1:0]       position_q, position_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;

  logic                     accept;
  logic                     emit;
  logic                     emit_up;
  logic signed [PEND_W-1:0] accept_delta;
  logic signed [PEND_W-1:0] emit_delta;

  // Next-state: accept, emit and the combined pending update.
  always_comb begin
    phase_d      = phase_q;
    position_d   = position_q;
    dwell_d      = dwell_q;
    accept_delta = '0;
    emit_delta   = '0;

    accept  = step_valid && ready_q;
    emit    = (dwell_q == DWELL_MAX) && (pending_q != '0);
    emit_up = !pending_q[PEND_W-1];

    if (accept) begin
      accept_delta = step_dir ? UNIT_P : -UNIT_P;
    end

    if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + DW'(1);
    end

    if (emit) begin
      dwell_d = '0;
      if (emit_up) begin
        emit_delta = ONE_P;
        position_d = position_q + COUNT_W'(1);
        unique case (phase_q)
          2'b00:   phase_d = 2'b10;
          2'b10:   phase_d = 2'b11;
          2'b11:   phase_d = 2'b01;
          default: phase_d = 2'b00;
        endcase
      end else begin
        emit_delta = -ONE_P;
        position_d = position_q - COUNT_W'(1);
        unique case (phase_q)
          2'b00:   phase_d = 2'b01;
          2'b01:   phase_d = 2'b11;
          2'b11:   phase_d = 2'b10;
          default: phase_d = 2'b00;
        endcase
      end
    end

    pending_d = pending_q + accept_delta - emit_delta;
    busy_d    = (pending_d != '0);
    // Ready stays high only while one more full request still fits.
    ready_d   = (pending_d < POS_LIM) && (pending_d > NEG_LIM);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 2'b00;
      pending_q  <= '0;
      dwell_q    <= DWELL_MAX;
      position_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      dwell_q    <= dwell_d;
      position_q <= position_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign a          = phase_q[1];
  assign b          = phase_q[0];
  assign position   = position_q;
  assign step_ready = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
module tb_quadrature_step_generator;

  logic       clk;
  logic       rst;
  logic       step_valid;
  logic       step_dir;
  logic       step_ready;
  logic       a;
  logic       b;
  logic [7:0] position;
  logic       busy;

  int total;
  int bad;
  int dec_cnt;
  int edge_cnt;
  logic [1:0] prev_ab;

  quadrature_step_generator #(
    .STEP_DIV (4),
    .PEND_W   (4),
    .COUNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .a          (a),
    .b          (b),
    .position   (position),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int quad_delta(input logic [1:0] from, input logic [1:0] to);
    case ({from, to})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return 1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return -1;
      default: return 0;
    endcase
  endfunction

  // Far-end decoder model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      dec_cnt  <= 0;
      edge_cnt <= 0;
      prev_ab  <= 2'b00;
    end else begin
      prev_ab <= {a, b};
      if ({a, b} != prev_ab) begin
        edge_cnt <= edge_cnt + 1;
        dec_cnt  <= dec_cnt + quad_delta(prev_ab, {a, b});
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    step_valid = 1'b0;
    step_dir   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    step_valid = 1'b0;
    step_dir   = 1'b0;

    do_reset();
    check_eq("rst_ab",    32'({a, b}),   32'h0);
    check_eq("rst_pos",   32'(position), 32'h0);
    check_eq("rst_busy",  32'(busy),     32'h0);
    check_eq("rst_ready", 32'(step_ready), 32'h1);

`ifdef QUADGEN_DETENT_EN
    // One detent up: four edges, phase back to 00, position 4.
    step_valid = 1'b1;
    step_dir   = 1'b1;
    tick();
    step_valid = 1'b0;
    check_eq("det_ready_lo", 32'(step_ready), 32'h0);
    check_eq("det_busy",     32'(busy),       32'h1);
    tick();
    check_eq("det_e1_ab",    32'({a, b}),     32'h2);
    check_eq("det_e1_ready", 32'(step_ready), 32'h1);
    for (int i = 3; i <= 14; i++) begin
      tick();
      if (i == 5)  check_eq("det_e1_hold", 32'({a, b}), 32'h2);
      if (i == 6)  check_eq("det_e2_ab",   32'({a, b}), 32'h3);
      if (i == 10) check_eq("det_e3_ab",   32'({a, b}), 32'h1);
    end
    check_eq("det_e4_ab",   32'({a, b}),   32'h0);
    check_eq("det_pos",     32'(position), 32'h4);
    check_eq("det_busy_lo", 32'(busy),     32'h0);
    tick();
    check_eq("det_dec", 32'(dec_cnt),  32'd4);
    check_eq("det_edges", 32'(edge_cnt), 32'd4);
`else
    // Single up request: edge registered one cycle after acceptance.
    step_valid = 1'b1;
    step_dir   = 1'b1;
    tick();
    step_valid = 1'b0;
    check_eq("t1_acc_ab",   32'({a, b}),   32'h0);
    check_eq("t1_acc_busy", 32'(busy),     32'h1);
    tick();
    check_eq("t1_ab",    32'({a, b}),     32'h2);
    check_eq("t1_pos",   32'(position),   32'h1);
    check_eq("t1_busy",  32'(busy),       32'h0);
    check_eq("t1_ready", 32'(step_ready), 32'h1);

    // Three ups back-to-back: edges at cycles 2, 6, 10.
    do_reset();
    step_valid = 1'b1;
    step_dir   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) step_valid = 1'b0;
      if (i == 2) check_eq("t2_e1_ab", 32'({a, b}), 32'h2);
      if (i == 5) check_eq("t2_e1_hold", 32'({a, b}), 32'h2);
      if (i == 6) check_eq("t2_e2_ab", 32'({a, b}), 32'h3);
      if (i == 9) check_eq("t2_e2_hold", 32'({a, b}), 32'h3);
    end
    check_eq("t2_e3_ab", 32'({a, b}),   32'h1);
    check_eq("t2_pos",   32'(position), 32'h3);
    check_eq("t2_busy",  32'(busy),     32'h0);
    tick();
    check_eq("t2_dec",   32'(dec_cnt),  32'd3);
    check_eq("t2_edges", 32'(edge_cnt), 32'd3);

    // Up, up, down: the down cancels the second up, one edge only.
    do_reset();
    step_valid = 1'b1;
    step_dir   = 1'b1;
    tick();
    tick();
    step_dir = 1'b0;
    tick();
    step_valid = 1'b0;
    check_eq("t3_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("t3_ab",    32'({a, b}),   32'h2);
    check_eq("t3_pos",   32'(position), 32'h1);
    check_eq("t3_edges", 32'(edge_cnt), 32'd1);
    check_eq("t3_dec",   32'(dec_cnt),  32'd1);

    // Held down requests: saturation at -7, drain every 4 cycles, wrap below 0.
    do_reset();
    step_valid = 1'b1;
    step_dir   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 2) begin
        check_eq("t4_wrap_pos", 32'(position), 32'hFF);
        check_eq("t4_wrap_ab",  32'({a, b}),   32'h1);
      end
      if (i == 8)  check_eq("t4_ready_h8",  32'(step_ready), 32'h1);
      if (i == 9)  check_eq("t4_ready_h9",  32'(step_ready), 32'h0);
      if (i == 10) begin
        check_eq("t4_ready_h10", 32'(step_ready), 32'h1);
        check_eq("t4_pos_h10",   32'(position),   32'hFD);
        check_eq("t4_ab_h10",    32'({a, b}),     32'h2);
      end
      if (i == 11) check_eq("t4_ready_h11", 32'(step_ready), 32'h0);
      if (i == 13) check_eq("t4_ready_h13", 32'(step_ready), 32'h0);
      if (i == 14) begin
        check_eq("t4_ready_h14", 32'(step_ready), 32'h1);
        check_eq("t4_pos_h14",   32'(position),   32'hFC);
        check_eq("t4_ab_h14",    32'({a, b}),     32'h0);
      end
    end
    step_valid = 1'b0;
    check_eq("t4_pos_end", 32'(position), 32'hFB);
    tick();
    check_eq("t4_dec", 32'(dec_cnt), 32'(-5));

    // Reset mid-dwell with pending = +5.
    do_reset();
    step_valid = 1'b1;
    step_dir   = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    step_valid = 1'b0;
    check_eq("t5_pre_ab",   32'({a, b}),   32'h3);
    check_eq("t5_pre_pos",  32'(position), 32'h2);
    check_eq("t5_pre_busy", 32'(busy),     32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_rst_ab",    32'({a, b}),     32'h0);
    check_eq("t5_rst_pos",   32'(position),   32'h0);
    check_eq("t5_rst_busy",  32'(busy),       32'h0);
    check_eq("t5_rst_ready", 32'(step_ready), 32'h1);
    for (int i = 0; i < 8; i++) tick();
    check_eq("t5_idle_ab",  32'({a, b}),   32'h0);
    check_eq("t5_idle_pos", 32'(position), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
